// File: rtl/reservation_station_if.sv
// Issue/broadcast/dispatch bundle between the issue stage, the CDBs, the
// reservation station and the ALU.
interface reservation_station_if #(parameter int ROB_W = 4);
  logic             ISS_sgn;
  logic [5:0]       ISS_opcode;
  logic [ROB_W-1:0] ISS_ROB_name;
  logic [31:0]      ISS_Vj, ISS_Vk;
  logic             ISS_Rj, ISS_Rk;
  logic [ROB_W-1:0] ISS_Qj, ISS_Qk;
  logic             CDB_sgn;
  logic [ROB_W-1:0] CDB_ROB_name;
  logic [31:0]      CDB_result;
  logic             LCDB_sgn;
  logic [ROB_W-1:0] LCDB_ROB_name;
  logic [31:0]      LCDB_result;
  logic             RS_full;
  logic             ALU_sgn;
  logic [5:0]       ALU_opcode;
  logic [ROB_W-1:0] ALU_ROB_name;
  logic [31:0]      ALU_lhs, ALU_rhs;

  modport master (
    output ISS_sgn, ISS_opcode, ISS_ROB_name, ISS_Vj, ISS_Vk, ISS_Rj, ISS_Rk, ISS_Qj, ISS_Qk,
    output CDB_sgn, CDB_ROB_name, CDB_result, LCDB_sgn, LCDB_ROB_name, LCDB_result,
    input  RS_full, ALU_sgn, ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs
  );
  modport slave (
    input  ISS_sgn, ISS_opcode, ISS_ROB_name, ISS_Vj, ISS_Vk, ISS_Rj, ISS_Rk, ISS_Qj, ISS_Qk,
    input  CDB_sgn, CDB_ROB_name, CDB_result, LCDB_sgn, LCDB_ROB_name, LCDB_result,
    output RS_full, ALU_sgn, ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs
  );
endinterface

// File: rtl/reservation_station.sv
// ALU-path reservation station: tag-tracked operand wakeup from CDB/LCDB and
// lowest-index single dispatch per cycle into registered ALU outputs.
module rs_entry #(parameter int ROB_W = 4) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             alloc,
  input  logic             disp,
  input  logic [5:0]       iss_opcode,
  input  logic [ROB_W-1:0] iss_rob,
  input  logic [31:0]      iss_vj, iss_vk,
  input  logic             iss_rj, iss_rk,
  input  logic [ROB_W-1:0] iss_qj, iss_qk,
  input  logic             cdb_sgn,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_res,
  input  logic             lcdb_sgn,
  input  logic [ROB_W-1:0] lcdb_tag,
  input  logic [31:0]      lcdb_res,
  output logic             busy,
  output logic             ready,
  output logic [5:0]       opcode,
  output logic [ROB_W-1:0] rob,
  output logic [31:0]      vj, vk
);
  logic             rj, rk;
  logic [ROB_W-1:0] qj, qk;
  logic [32:0]      wj, wk, bj, bk;

  // {hit, value}; CDB is applied last so it wins when both buses carry the tag
  function automatic logic [32:0] snoop(input logic [ROB_W-1:0] q);
    snoop = '0;
    if (lcdb_sgn && lcdb_tag == q) snoop = {1'b1, lcdb_res};
    if (cdb_sgn && cdb_tag == q)   snoop = {1'b1, cdb_res};
  endfunction

  assign wj = snoop(qj);
  assign wk = snoop(qk);
  assign bj = snoop(iss_qj);
  assign bk = snoop(iss_qk);
  assign ready = busy & rj & rk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0; rj <= 1'b0; rk <= 1'b0;
      opcode <= '0; rob <= '0; vj <= '0; vk <= '0; qj <= '0; qk <= '0;
    end else if (clr) begin
      busy <= 1'b0;
    end else if (en) begin
      if (alloc) begin
        busy   <= 1'b1;
        opcode <= iss_opcode;
        rob    <= iss_rob;
        qj     <= iss_qj;
        qk     <= iss_qk;
        rj     <= iss_rj | bj[32];
        rk     <= iss_rk | bk[32];
        vj     <= iss_rj ? iss_vj : bj[31:0];
        vk     <= iss_rk ? iss_vk : bk[31:0];
      end else if (busy) begin
        if (disp) busy <= 1'b0;
        if (!rj && wj[32]) begin rj <= 1'b1; vj <= wj[31:0]; end
        if (!rk && wk[32]) begin rk <= 1'b1; vk <= wk[31:0]; end
      end
    end
  end
endmodule

module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic ROB_clr,
  reservation_station_if.slave bus
);
  logic [RS_SIZE-1:0]            busy, ready, free_oh, pick_oh, alloc, disp;
  logic [RS_SIZE-1:0][5:0]       e_op;
  logic [RS_SIZE-1:0][ROB_W-1:0] e_rob;
  logic [RS_SIZE-1:0][31:0]      e_vj, e_vk;
  logic                          en, clr, iss_go;
  logic [5:0]                    sel_op;
  logic [ROB_W-1:0]              sel_rob;
  logic [31:0]                   sel_vj, sel_vk;
  logic                          alu_sgn;
  logic [5:0]                    alu_op;
  logic [ROB_W-1:0]              alu_rob;
  logic [31:0]                   alu_lhs, alu_rhs;

  assign en      = rdy & ~ROB_clr;
  assign clr     = rdy & ROB_clr;
  assign bus.RS_full = &busy;
  assign iss_go  = en & bus.ISS_sgn & ~(&busy);
  // isolate lowest free / lowest ready slot as one-hot
  assign free_oh = ~busy & (busy + RS_SIZE'(1));
  assign pick_oh = ready & (~ready + RS_SIZE'(1));
  assign alloc   = free_oh & {RS_SIZE{iss_go}};
  assign disp    = pick_oh & {RS_SIZE{en}};

  for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
    rs_entry #(.ROB_W(ROB_W)) u_ent (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .alloc(alloc[i]), .disp(disp[i]),
      .iss_opcode(bus.ISS_opcode), .iss_rob(bus.ISS_ROB_name),
      .iss_vj(bus.ISS_Vj), .iss_vk(bus.ISS_Vk), .iss_rj(bus.ISS_Rj), .iss_rk(bus.ISS_Rk),
      .iss_qj(bus.ISS_Qj), .iss_qk(bus.ISS_Qk),
      .cdb_sgn(bus.CDB_sgn), .cdb_tag(bus.CDB_ROB_name), .cdb_res(bus.CDB_result),
      .lcdb_sgn(bus.LCDB_sgn), .lcdb_tag(bus.LCDB_ROB_name), .lcdb_res(bus.LCDB_result),
      .busy(busy[i]), .ready(ready[i]), .opcode(e_op[i]), .rob(e_rob[i]),
      .vj(e_vj[i]), .vk(e_vk[i])
    );
  end

  always_comb begin
    sel_op = '0; sel_rob = '0; sel_vj = '0; sel_vk = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (pick_oh[i]) begin
        sel_op = e_op[i]; sel_rob = e_rob[i]; sel_vj = e_vj[i]; sel_vk = e_vk[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_sgn <= 1'b0; alu_op <= '0; alu_rob <= '0; alu_lhs <= '0; alu_rhs <= '0;
    end else if (!en || !(|ready)) begin
      alu_sgn <= 1'b0;
    end else begin
      alu_sgn <= 1'b1; alu_op <= sel_op; alu_rob <= sel_rob;
      alu_lhs <= sel_vj; alu_rhs <= sel_vk;
    end
  end

  assign bus.ALU_sgn      = alu_sgn;
  assign bus.ALU_opcode   = alu_op;
  assign bus.ALU_ROB_name = alu_rob;
  assign bus.ALU_lhs      = alu_lhs;
  assign bus.ALU_rhs      = alu_rhs;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, wakeup, bypass, fill, flush,
// stall and asynchronous reset scenarios with hand-computed expectations.
module tb_reservation_station;
  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_AND = 6'd3,
                         OP_OR  = 6'd4, OP_XOR = 6'd5;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, ROB_clr = 1'b0;
  int checks = 0, errors = 0;

  reservation_station_if #(.ROB_W(4)) bus ();
  reservation_station #(.RS_SIZE(16), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ROB_clr(ROB_clr), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [3:0] rob, input logic [31:0] vj, vk,
                       input logic rj, rk, input logic [3:0] qj, qk);
    bus.ISS_sgn = 1'b1; bus.ISS_opcode = op; bus.ISS_ROB_name = rob;
    bus.ISS_Vj = vj; bus.ISS_Vk = vk; bus.ISS_Rj = rj; bus.ISS_Rk = rk;
    bus.ISS_Qj = qj; bus.ISS_Qk = qk;
  endtask

  task automatic idle();
    bus.ISS_sgn = 1'b0; bus.CDB_sgn = 1'b0; bus.LCDB_sgn = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.ISS_opcode = '0; bus.ISS_ROB_name = '0; bus.ISS_Vj = '0; bus.ISS_Vk = '0;
    bus.ISS_Rj = 1'b0; bus.ISS_Rk = 1'b0; bus.ISS_Qj = '0; bus.ISS_Qk = '0;
    bus.CDB_ROB_name = '0; bus.CDB_result = '0; bus.LCDB_ROB_name = '0; bus.LCDB_result = '0;
    #2;
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL reset_sgn: got %b expected 0", bus.ALU_sgn); end
    checks++; if (bus.RS_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.RS_full); end
    checks++; if ({bus.ALU_opcode, bus.ALU_ROB_name, bus.ALU_lhs, bus.ALU_rhs} !== 74'd0) begin
      errors++; $display("FAIL reset_fields: got op=%h rob=%h lhs=%h rhs=%h expected all 0",
                         bus.ALU_opcode, bus.ALU_ROB_name, bus.ALU_lhs, bus.ALU_rhs); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    issue(OP_ADD, 4'd1, 32'd5, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); idle();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", bus.ALU_sgn); end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_opcode !== OP_ADD || bus.ALU_ROB_name !== 4'd1) begin
      errors++; $display("FAIL basic_disp: got sgn=%b op=%h rob=%h expected 1 %h 1", bus.ALU_sgn, bus.ALU_opcode, bus.ALU_ROB_name, OP_ADD); end
    checks++; if (bus.ALU_lhs !== 32'd5 || bus.ALU_rhs !== 32'd7) begin
      errors++; $display("FAIL basic_ops: got lhs=%h rhs=%h expected 5 7", bus.ALU_lhs, bus.ALU_rhs); end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL basic_after: got %b expected 0", bus.ALU_sgn); end
  endtask

  task automatic test_wakeup();
    issue(OP_SUB, 4'd2, 32'hDEAD, 32'd1, 1'b0, 1'b1, 4'd3, 4'd0);
    tick(); idle();
    tick();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL wake_wait: got %b expected 0", bus.ALU_sgn); end
    bus.CDB_sgn = 1'b1; bus.CDB_ROB_name = 4'd3; bus.CDB_result = 32'h10;
    tick(); idle();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL wake_same_edge: got %b expected 0", bus.ALU_sgn); end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_opcode !== OP_SUB || bus.ALU_lhs !== 32'h10 || bus.ALU_rhs !== 32'd1) begin
      errors++; $display("FAIL wake_disp: got sgn=%b op=%h lhs=%h rhs=%h expected 1 %h 10 1",
                         bus.ALU_sgn, bus.ALU_opcode, bus.ALU_lhs, bus.ALU_rhs, OP_SUB); end
    tick();
  endtask

  task automatic test_bypass();
    issue(OP_ADD, 4'd4, 32'd2, 32'hDEAD, 1'b1, 1'b0, 4'd0, 4'd5);
    bus.LCDB_sgn = 1'b1; bus.LCDB_ROB_name = 4'd5; bus.LCDB_result = 32'hAB;
    tick(); idle();
    tick();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_lhs !== 32'd2 || bus.ALU_rhs !== 32'hAB || bus.ALU_ROB_name !== 4'd4) begin
      errors++; $display("FAIL bypass: got sgn=%b lhs=%h rhs=%h rob=%h expected 1 2 ab 4",
                         bus.ALU_sgn, bus.ALU_lhs, bus.ALU_rhs, bus.ALU_ROB_name); end
    tick();
    // both buses carry tag 6 in one cycle (CDB must win), LCDB alone wakes tag 7 later
    issue(OP_OR, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0, 4'd6, 4'd7);
    tick(); idle();
    bus.CDB_sgn = 1'b1; bus.CDB_ROB_name = 4'd6; bus.CDB_result = 32'h11;
    bus.LCDB_sgn = 1'b1; bus.LCDB_ROB_name = 4'd6; bus.LCDB_result = 32'h22;
    tick(); idle();
    bus.LCDB_sgn = 1'b1; bus.LCDB_ROB_name = 4'd7; bus.LCDB_result = 32'h33;
    tick(); idle();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL cdb_pri_early: got %b expected 0", bus.ALU_sgn); end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_lhs !== 32'h11 || bus.ALU_rhs !== 32'h33) begin
      errors++; $display("FAIL cdb_priority: got sgn=%b lhs=%h rhs=%h expected 1 11 33", bus.ALU_sgn, bus.ALU_lhs, bus.ALU_rhs); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 4'(i), 32'd0, 32'(i), 1'b0, 1'b1, 4'd9, 4'd0);
      tick();
      if (i == 14) begin
        checks++; if (bus.RS_full !== 1'b0) begin errors++; $display("FAIL full_at15: got %b expected 0", bus.RS_full); end
      end
    end
    checks++; if (bus.RS_full !== 1'b1) begin errors++; $display("FAIL full_at16: got %b expected 1", bus.RS_full); end
    issue(OP_XOR, 4'hF, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); idle();
    checks++; if (bus.RS_full !== 1'b1 || bus.ALU_sgn !== 1'b0) begin
      errors++; $display("FAIL full_17th: got full=%b sgn=%b expected 1 0", bus.RS_full, bus.ALU_sgn); end
    bus.CDB_sgn = 1'b1; bus.CDB_ROB_name = 4'd9; bus.CDB_result = 32'h99;
    tick(); idle();
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_ROB_name !== 4'(i) || bus.ALU_opcode !== OP_ADD ||
                    bus.ALU_lhs !== 32'h99 || bus.ALU_rhs !== 32'(i)) begin
        errors++; $display("FAIL full_drain%0d: got sgn=%b rob=%h op=%h lhs=%h rhs=%h expected 1 %h %h 99 %h",
                           i, bus.ALU_sgn, bus.ALU_ROB_name, bus.ALU_opcode, bus.ALU_lhs, bus.ALU_rhs, i, OP_ADD, i); end
      if (i == 0) begin
        checks++; if (bus.RS_full !== 1'b0) begin errors++; $display("FAIL full_drop: got %b expected 0", bus.RS_full); end
      end
    end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", bus.ALU_sgn); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      issue(OP_ADD, 4'(i), 32'd0, 32'd0, 1'b0, 1'b1, 4'd10, 4'd0);
      tick();
    end
    ROB_clr = 1'b1;
    issue(OP_SUB, 4'd7, 32'd1, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); idle(); ROB_clr = 1'b0;
    checks++; if (bus.RS_full !== 1'b0 || bus.ALU_sgn !== 1'b0) begin
      errors++; $display("FAIL flush_state: got full=%b sgn=%b expected 0 0", bus.RS_full, bus.ALU_sgn); end
    bus.CDB_sgn = 1'b1; bus.CDB_ROB_name = 4'd10; bus.CDB_result = 32'h5A;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL flush_nodisp%0d: got %b expected 0", i, bus.ALU_sgn); end
    end
  endtask

  task automatic test_stall();
    issue(OP_AND, 4'd3, 32'h55, 32'h66, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ROB_clr = (i == 1);
      tick();
      checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL stall%0d: got %b expected 0", i, bus.ALU_sgn); end
    end
    ROB_clr = 1'b0; rdy = 1'b1;
    tick();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_opcode !== OP_AND || bus.ALU_lhs !== 32'h55 || bus.ALU_rhs !== 32'h66) begin
      errors++; $display("FAIL stall_resume: got sgn=%b op=%h lhs=%h rhs=%h expected 1 %h 55 66",
                         bus.ALU_sgn, bus.ALU_opcode, bus.ALU_lhs, bus.ALU_rhs, OP_AND); end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL stall_once: got %b expected 0", bus.ALU_sgn); end
  endtask

  task automatic test_back_to_back();
    issue(OP_ADD, 4'd5, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0);
    tick();
    issue(OP_SUB, 4'd6, 32'd2, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); idle();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_ROB_name !== 4'd5) begin
      errors++; $display("FAIL b2b_first: got sgn=%b rob=%h expected 1 5", bus.ALU_sgn, bus.ALU_ROB_name); end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_ROB_name !== 4'd6 || bus.ALU_lhs !== 32'd2) begin
      errors++; $display("FAIL b2b_second: got sgn=%b rob=%h lhs=%h expected 1 6 2", bus.ALU_sgn, bus.ALU_ROB_name, bus.ALU_lhs); end
    tick();
    checks++; if (bus.ALU_sgn !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", bus.ALU_sgn); end
  endtask

  task automatic test_async_reset();
    issue(OP_OR, 4'd8, 32'h77, 32'h88, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); idle();
    tick();
    checks++; if (bus.ALU_sgn !== 1'b1 || bus.ALU_lhs !== 32'h77) begin
      errors++; $display("FAIL areset_pre: got sgn=%b lhs=%h expected 1 77", bus.ALU_sgn, bus.ALU_lhs); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.ALU_sgn !== 1'b0 || bus.ALU_lhs !== 32'd0 || bus.ALU_rhs !== 32'd0 ||
                  bus.ALU_opcode !== 6'd0 || bus.ALU_ROB_name !== 4'd0) begin
      errors++; $display("FAIL areset_out: got sgn=%b op=%h rob=%h lhs=%h rhs=%h expected all 0",
                         bus.ALU_sgn, bus.ALU_opcode, bus.ALU_ROB_name, bus.ALU_lhs, bus.ALU_rhs); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
# reservation_station

Issue-side reservation station for the ALU path of the out-of-order core. It buffers up to `RS_SIZE` decoded integer/branch/JALR operations and tracks pending source operands by ROB tag. It snoops the ALU and LSB common data buses to wake operands, and dispatches one ready operation per cycle into the ALU's `RS_*` inputs through registered outputs. It sits between the issue stage and the ALU and is cleared on ROB flush.

## Interface
- `RS_SIZE`, 16, number of entries (power of two, ≥2)
- `ROB_W`, 4, ROB tag width (matches `` `ROBID ``)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rdy`  in  1  global ready; low = stall
- `ROB_clr`  in  1  flush all entries (mispredict)
- `ISS_sgn`  in  1  issue request
- `ISS_opcode`  in  6  internal opcode (`` `ADD `` … `` `JALR ``)
- `ISS_ROB_name`  in  ROB_W  destination tag
- `ISS_Vj`, `ISS_Vk`  in  32  operand values (valid when matching ready bit set)
- `ISS_Rj`, `ISS_Rk`  in  1  operand ready flags
- `ISS_Qj`, `ISS_Qk`  in  ROB_W  producer tags when not ready
- `CDB_sgn`, `CDB_ROB_name`, `CDB_result`  in  1/ROB_W/32  ALU broadcast
- `LCDB_sgn`, `LCDB_ROB_name`, `LCDB_result`  in  1/ROB_W/32  LSB broadcast
- `RS_full`  out  1  no free entry (combinational from registered state)
- `ALU_sgn`  out  1  dispatch valid (registered)
- `ALU_opcode`  out  6  (registered)
- `ALU_ROB_name`  out  ROB_W  (registered)
- `ALU_lhs`, `ALU_rhs`  out  32  Vj, Vk (registered)

## Operation
- Per entry: `busy`, `opcode`, `rob`, `Vj`, `Vk`, `Rj`, `Rk`, `Qj`, `Qk`.
- Priority per edge (`rdy` high): flush > {wakeup, issue, dispatch} (the latter three are concurrent).
- Flush: `ROB_clr`=1 → all `busy`←0, `ALU_sgn`←0; the issue in that cycle is dropped.
- Issue: `ISS_sgn`=1 and `RS_full`=0 → write the lowest-index non-busy entry, `busy`←1.
  - `ISS_sgn` while `RS_full`=1 is ignored (issuer's fault; no state change).
- Issue bypass: operand not ready and its Q equals a same-cycle `CDB`/`LCDB` tag → store the bus result, mark ready.
- Wakeup: every busy entry with `R`=0 and `Q` equal to a valid bus tag → `V`←result, `R`←1.
  - Both buses may hit the same entry in the same cycle (different operands, or the same tag on both). If both buses match the same operand, `CDB` wins.
- Dispatch: select the lowest-index entry with `busy`&`Rj`&`Rk`, evaluated on the current registered state (a wakeup in this cycle does not make an entry eligible until the next cycle).
  - Selected entry → `ALU_*`←its fields, `ALU_sgn`←1, `busy`←0.
  - No candidate → `ALU_sgn`←0; other `ALU_*` hold.
- `RS_full` = all `busy`. A slot freed by a dispatch becomes usable from the next cycle.
- Stall (`rdy`=0): entry state holds, `ALU_sgn`←0 (no duplicate dispatch), bus inputs ignored.
- Reset: all `busy`/`R`←0; `ALU_sgn`, `ALU_opcode`, `ALU_ROB_name`, `ALU_lhs`, `ALU_rhs`←0; `RS_full`=0.

## Timing
- Issue with both operands ready at edge N → `ALU_sgn`=1 after edge N+1 (one cycle in station); ALU result appears on `CDB` in that same cycle.
- Operand woken by a broadcast during cycle N → entry eligible for dispatch at edge N+1.
- A dependent instruction issued in the cycle its producer broadcasts captures the value via bypass (no lost wakeup).
- Throughput: one dispatch per cycle.
- Issue, dispatch and wakeup touching the same entry in one cycle is impossible by construction: issue targets only free entries, dispatch only busy ones.
- `ROB_clr` asserted mid-stall has no effect until a `rdy`=1 edge.
- Reset is asynchronous and may assert mid-dispatch; outputs go to reset values immediately.

## Test plan
- Reset, then issue ADD Vj=5, Vk=7, both ready → one cycle later `ALU_sgn`=1, opcode `` `ADD ``, lhs=5, rhs=7; following cycle `ALU_sgn`=0.
- Issue SUB with Rj=0, Qj=3; later `CDB` tag 3 result=0x10 → `ALU_lhs`=0x10 on the cycle after the broadcast; no dispatch before it.
- Issue with Qk=5 in the same cycle `LCDB` tag 5 carries 0xAB → dispatches next cycle with rhs=0xAB (bypass).
- Fill 16 entries whose operands depend on tag 9 → `RS_full`=1, a 17th issue is ignored. Broadcast tag 9 → 16 dispatches in index order, one per cycle; `RS_full` drops after the first.
- Fill 4 entries, assert `ROB_clr` together with an `ISS_sgn` → all freed, nothing dispatched afterwards, `RS_full`=0.
- Ready entry present, hold `rdy`=0 for 3 cycles → `ALU_sgn`=0 throughout; exactly one dispatch after `rdy` returns high.
